sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
- Reader side of the 16x16 RGB sprite ROM.
- Takes the VGA pixel stream (coordinates, background colour) and sprite position, drives the ROM address, and composites the sprite over the background with colour-key transparency.
- Sits between the VGA timing generator and the DAC output register.
- Sprite position is double-buffered and committed only at frame start, so no tearing.

Parameters:
- SPRITE_W, 16, sprite width in pixels (power of two)
- SPRITE_H, 16, sprite height in pixels
- X_W, 10, pixel/position X width
- Y_W, 10, pixel/position Y width
- ADDR_W, 8, ROM address width (log2(SPRITE_W*SPRITE_H))
- KEY_RGB, 24'h000000, transparent colour key

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  active-video pixel this cycle
- pix_x  in  X_W  current pixel column
- pix_y  in  Y_W  current pixel row
- bg_rgb  in  24  background colour for this pixel
- frame_start  in  1  one-cycle pulse at start of vertical blank
- sprite_en  in  1  sprite visible (sampled with pixel)
- pos_wr  in  1  write new sprite position into pending buffer
- pos_x_in  in  X_W  new top-left X
- pos_y_in  in  Y_W  new top-left Y
- pos_ack  out  1  one-cycle pulse: pending position committed
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  24  ROM colour (combinational ROM, same cycle as rom_addr)
- out_valid  out  1  out_rgb valid
- out_rgb  out  24  composited pixel
- out_hit  out  1  opaque sprite pixel shown

Behaviour:
- Reset (async, rst_n=0): active_x/active_y=0, pending regs=0, pending flag=0, rom_addr=0, out_valid=0, out_rgb=0, out_hit=0, pos_ack=0, all pipeline regs cleared. Release is synchronous to clk.
- Position buffer:
  - pos_wr loads the pending regs and sets the pending flag; a later pos_wr before commit overwrites (last write wins).
  - frame_start with pending=1: active <= pending, pending flag cleared, pos_ack=1 next cycle for exactly one cycle.
  - frame_start with pending=0: nothing changes, no ack.
  - pos_wr and frame_start in the same cycle: the incoming pos_x_in/pos_y_in are committed directly, pending flag cleared, ack issued.
- Hit test:
  - dx = pix_x - active_x, dy = pix_y - active_y, each computed at width+1 bits.
  - in_box = both differences non-negative AND dx<SPRITE_W AND dy<SPRITE_H AND sprite_en AND pix_valid.
  - No wrap-around: pix_x<active_x is never a hit. Sprites partially off the right/bottom edge clip naturally.
- Stage 1 (registered, at the edge after the input cycle):
  - rom_addr = dy*SPRITE_W + dx, truncated to ADDR_W, when in_box; otherwise rom_addr holds its previous value.
  - Also registers in_box, bg_rgb and pix_valid.
- Stage 2 (registered):
  - out_valid = s1_valid.
  - opaque = s1_in_box AND rom_data != KEY_RGB.
  - out_rgb = opaque ? rom_data : (s1_valid ? s1_bg : 24'h0); out_hit = opaque.
- Latency: exactly 2 clocks from pix_* to out_*, fully pipelined, one pixel per clock, no stalls.
- Invalid pixels: pix_valid=0 gives out_valid=0, out_rgb=0, out_hit=0 two cycles later.
- Mid-frame position: pos_wr during active video never affects the current frame.
- Reset mid-line: pipeline is flushed and outputs go to 0 immediately (asynchronous). Pending writes are lost.

Test Plan:
- Commit, then opaque pixel: pos_wr (100,50), frame_start → pos_ack pulse next cycle. Then pix (107,51), bg 0000FF → rom_addr=23 after 1 clk; with ROM returning FF0000, out_rgb=FF0000, out_hit=1, out_valid=1 after 2 clks.
- Miss on both sides: active (100,50); pix (99,50) → out_rgb=bg, out_hit=0. pix (116,50) → also bg.
- Colour-key transparency: pix (100,50), addr 0, ROM 000000, bg 00FF00 → out_rgb=00FF00, out_hit=0.
- No tearing, and simultaneous write+commit:
  - pos_wr (200,60) mid-frame → pixels still rendered at (100,50), no ack, until frame_start; then ack, and (200,60) is active.
  - pos_wr and frame_start in the same cycle → committed immediately, single ack.
- Right-edge clipping and pipelining:
  - active (630,0); pix (639,0) → addr 9, hit.
  - pix (5,0) → no hit.
  - Back-to-back pixels 630..645 produce 16 consecutive outputs, no bubbles.
- Reset and gating:
  - rst_n low mid-stream → out_valid/out_rgb/out_hit/pos_ack = 0 at once.
  - After release with sprite_en=0 → output equals bg for every valid pixel.

Source files
------------

// File: rtl/sprite_renderer.sv
// -----------------------------------------------------------------------------
// sprite_renderer
//
// Reader side of the sprite ROM. Takes the VGA pixel stream and a sprite
// position, drives the ROM address and composites the sprite over the
// background, treating KEY_RGB as transparent. The sprite position is
// double-buffered: writes land in a pending buffer and only become active at
// frame_start, so a frame is never rendered with two different positions.
//
// Pipeline: pixel inputs -> stage 1 (rom_addr, in_box, bg, valid)
//                        -> stage 2 (out_valid, out_rgb, out_hit)
// Two clocks of latency, one pixel per clock, no stalls.
//
// Ports:
//   clk, rst_n             pixel clock, asynchronous active-low reset
//   pix_valid/x/y, bg_rgb  incoming pixel and its background colour
//   frame_start            one-cycle pulse at start of vertical blank
//   sprite_en              sprite visible for this pixel
//   pos_wr, pos_x_in/y_in  write new top-left position into pending buffer
//   pos_ack                one-cycle pulse after a position is committed
//   rom_addr / rom_data    registered ROM address, combinational ROM colour
//   out_valid/rgb/hit      composited pixel, hit = opaque sprite pixel shown
// -----------------------------------------------------------------------------
module sprite_renderer #(
  parameter int          SPRITE_W = 16,
  parameter int          SPRITE_H = 16,
  parameter int          X_W      = 10,
  parameter int          Y_W      = 10,
  parameter int          ADDR_W   = 8,
  parameter logic [23:0] KEY_RGB  = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic [X_W-1:0]    pix_x,
  input  logic [Y_W-1:0]    pix_y,
  input  logic [23:0]       bg_rgb,
  input  logic              frame_start,
  input  logic              sprite_en,
  input  logic              pos_wr,
  input  logic [X_W-1:0]    pos_x_in,
  input  logic [Y_W-1:0]    pos_y_in,
  output logic              pos_ack,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              out_valid,
  output logic [23:0]       out_rgb,
  output logic              out_hit
);

  localparam int SX_W = $clog2(SPRITE_W);
  localparam logic [X_W:0] SPR_W_X = (X_W+1)'(SPRITE_W);
  localparam logic [Y_W:0] SPR_H_Y = (Y_W+1)'(SPRITE_H);

  // ---------------------------------------------------------------------------
  // Position double buffer
  // ---------------------------------------------------------------------------
  logic [X_W-1:0] active_x, pend_x;
  logic [Y_W-1:0] active_y, pend_y;
  logic           pend_flag;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_x  <= '0;
      active_y  <= '0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_flag <= 1'b0;
      pos_ack   <= 1'b0;
    end else begin
      pos_ack <= 1'b0;
      if (frame_start && pos_wr) begin
        // A write arriving with the commit pulse bypasses the pending buffer.
        active_x  <= pos_x_in;
        active_y  <= pos_y_in;
        pend_flag <= 1'b0;
        pos_ack   <= 1'b1;
      end else if (frame_start && pend_flag) begin
        active_x  <= pend_x;
        active_y  <= pend_y;
        pend_flag <= 1'b0;
        pos_ack   <= 1'b1;
      end else if (pos_wr) begin
        pend_x    <= pos_x_in;
        pend_y    <= pos_y_in;
        pend_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hit test: one extra bit so a pixel left of / above the sprite shows up as
  // a negative difference instead of wrapping into the box.
  // ---------------------------------------------------------------------------
  logic [X_W:0]    dx;
  logic [Y_W:0]    dy;
  logic            x_ok, y_ok, in_box;
  logic [ADDR_W-1:0] addr_next;

  assign dx     = {1'b0, pix_x} - {1'b0, active_x};
  assign dy     = {1'b0, pix_y} - {1'b0, active_y};
  assign x_ok   = !dx[X_W] && (dx < SPR_W_X);
  assign y_ok   = !dy[Y_W] && (dy < SPR_H_Y);
  assign in_box = x_ok && y_ok && sprite_en && pix_valid;

  // SPRITE_W is a power of two and dx < SPRITE_W inside the box, so
  // dy*SPRITE_W + dx is a shift and an OR.
  assign addr_next = ADDR_W'({dy, {SX_W{1'b0}}}) | ADDR_W'(dx);

  // ---------------------------------------------------------------------------
  // Stage 1: ROM address and pixel context
  // ---------------------------------------------------------------------------
  logic        s1_valid, s1_in_box;
  logic [23:0] s1_bg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      s1_valid  <= 1'b0;
      s1_in_box <= 1'b0;
      s1_bg     <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_in_box <= in_box;
      s1_bg     <= bg_rgb;
      // Outside the box the address is a don't-care; holding it avoids
      // needless ROM address toggling.
      if (in_box) rom_addr <= addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: composite
  // ---------------------------------------------------------------------------
  logic opaque;
  assign opaque = s1_in_box && (rom_data != KEY_RGB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
      out_hit   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_hit   <= opaque;
      out_rgb   <= opaque ? rom_data : (s1_valid ? s1_bg : 24'h0);
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// -----------------------------------------------------------------------------
// tb_sprite_renderer
//
// Self-checking bench for sprite_renderer. A behavioural model tracks the
// active/pending sprite position and predicts each pixel's composited colour
// directly from the box test and ROM contents; directed scenarios are followed
// by a randomized stream.
// -----------------------------------------------------------------------------
module tb_sprite_renderer;

  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_valid;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [23:0]       bg_rgb;
  logic              frame_start;
  logic              sprite_en;
  logic              pos_wr;
  logic [X_W-1:0]    pos_x_in;
  logic [Y_W-1:0]    pos_y_in;
  logic              pos_ack;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic              out_valid;
  logic [23:0]       out_rgb;
  logic              out_hit;

  always #5 clk = ~clk;

  // Combinational sprite ROM
  logic [23:0] rom [0:255];
  assign rom_data = rom[rom_addr];

  sprite_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .bg_rgb      (bg_rgb),
    .frame_start (frame_start),
    .sprite_en   (sprite_en),
    .pos_wr      (pos_wr),
    .pos_x_in    (pos_x_in),
    .pos_y_in    (pos_y_in),
    .pos_ack     (pos_ack),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_rgb     (out_rgb),
    .out_hit     (out_hit)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_ax, m_ay, m_px, m_py;
  bit          m_pend;
  logic [25:0] m_pipe;   // {valid, hit, rgb} expected at the next edge
  logic [7:0]  m_addr;

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
    m_pend = 0; m_pipe = '0; m_addr = '0;
  endtask

  // Apply one pixel/control cycle, then check the DUT just after the edge.
  task automatic cycle(input bit pv, input int px, input int py, input logic [23:0] bg,
                       input bit en, input bit fs, input bit wr, input int wx, input int wy);
    bit          inbox, ack;
    int          a;
    logic [23:0] c;
    logic [25:0] nxt;
    pix_valid = pv; pix_x = 10'(px); pix_y = 10'(py); bg_rgb = bg;
    sprite_en = en; frame_start = fs; pos_wr = wr;
    pos_x_in = 10'(wx); pos_y_in = 10'(wy);
    @(posedge clk);
    #1;
    inbox = pv && en && px >= m_ax && px < m_ax + 16 && py >= m_ay && py < m_ay + 16;
    nxt = '0;
    if (inbox) begin
      a = (py - m_ay) * 16 + (px - m_ax);
      m_addr = 8'(a);
      c = rom[a];
      nxt = (c != 24'h0) ? {2'b11, c} : {2'b10, bg};
    end else if (pv) begin
      nxt = {2'b10, bg};
    end
    ack = 0;
    if (fs && wr) begin
      m_ax = wx; m_ay = wy; m_pend = 0; ack = 1;
    end else if (fs && m_pend) begin
      m_ax = m_px; m_ay = m_py; m_pend = 0; ack = 1;
    end else if (wr) begin
      m_px = wx; m_py = wy; m_pend = 1;
    end
    check("pos_ack", 32'(pos_ack), 32'(ack));
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("out", 32'({out_valid, out_hit, out_rgb}), 32'(m_pipe));
    m_pipe = nxt;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 24'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int px, input int py, input logic [23:0] bg);
    cycle(1, px, py, bg, 1, 0, 0, 0, 0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rgb",   32'(out_rgb),   32'd0);
    check("rst_out_hit",   32'(out_hit),   32'd0);
    check("rst_pos_ack",   32'(pos_ack),   32'd0);
    model_reset();
    pix_valid = 0; frame_start = 0; pos_wr = 0; sprite_en = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
    rom[23] = 24'hFF0000;
    rom[0]  = 24'h000000;
    rom[9]  = 24'h123456;

    rst_n = 1'b0;
    pix_valid = 0; pix_x = '0; pix_y = '0; bg_rgb = '0; frame_start = 0;
    sprite_en = 0; pos_wr = 0; pos_x_in = '0; pos_y_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_out",  32'({out_valid, out_hit, out_rgb}), 32'd0);
    check("reset_addr", 32'(rom_addr), 32'd0);
    check("reset_ack",  32'(pos_ack), 32'd0);

    // Commit then opaque pixel
    cycle(0, 0, 0, 24'h0, 0, 0, 1, 100, 50);
    check("no_ack_on_write", 32'(pos_ack), 32'd0);
    cycle(0, 0, 0, 24'h0, 0, 1, 0, 0, 0);
    check("ack_commit", 32'(pos_ack), 32'd1);
    idle();
    check("ack_one_cycle", 32'(pos_ack), 32'd0);
    pix(107, 51, 24'h0000FF);
    check("addr_23", 32'(rom_addr), 32'd23);
    idle();
    check("hit_rgb", 32'(out_rgb), 32'hFF0000);
    check("hit_flag", 32'({out_valid, out_hit}), 32'b11);

    // Misses on both sides, then colour key
    pix(99, 50, 24'hAAAAAA);
    pix(116, 50, 24'h555555);
    idle();
    check("miss_right_rgb", 32'(out_rgb), 32'h555555);
    pix(100, 50, 24'h00FF00);
    idle();
    check("key_rgb", 32'(out_rgb), 32'h00FF00);
    check("key_hit", 32'(out_hit), 32'd0);

    // No tearing: mid-frame write stays pending until frame_start
    cycle(1, 107, 51, 24'h0000FF, 1, 0, 1, 200, 60);
    pix(107, 51, 24'h0000FF);
    check("no_tear_ack", 32'(pos_ack), 32'd0);
    idle();
    check("no_tear_hit", 32'(out_rgb), 32'hFF0000);
    cycle(0, 0, 0, 24'h0, 0, 1, 0, 0, 0);
    check("tear_commit_ack", 32'(pos_ack), 32'd1);
    pix(207, 61, 24'h0000FF);
    idle();
    check("new_pos_hit", 32'(out_rgb), 32'hFF0000);

    // Simultaneous write + commit
    cycle(0, 0, 0, 24'h0, 0, 1, 1, 630, 0);
    check("simul_ack", 32'(pos_ack), 32'd1);
    idle();
    check("simul_single_ack", 32'(pos_ack), 32'd0);

    // Right-edge clipping and back-to-back pixels
    pix(639, 0, 24'h0F0F0F);
    check("addr_9", 32'(rom_addr), 32'd9);
    pix(5, 0, 24'h0F0F0F);
    check("edge_hit", 32'({out_hit, out_rgb}), 32'h1123456);
    for (int x = 630; x <= 645; x++) pix(x, 0, 24'(x));
    idle();
    idle();

    // Reset right after a commit (ack high, outputs valid)
    cycle(1, 635, 1, 24'h111111, 1, 1, 1, 20, 20);
    async_reset();
    // Pending write lost across reset
    cycle(0, 0, 0, 24'h0, 0, 0, 1, 400, 100);
    async_reset();
    cycle(0, 0, 0, 24'h0, 0, 1, 0, 0, 0);
    check("lost_pending_ack", 32'(pos_ack), 32'd0);

    // sprite_en=0: every valid pixel shows background
    for (int i = 0; i < 24; i++)
      cycle(1, $urandom_range(0, 20), $urandom_range(0, 20), 24'($urandom), 0, 0, 0, 0, 0);

    // Randomized stream
    for (int i = 0; i < 1500; i++) begin
      int px, py, wx, wy;
      px = ((m_ax + int'($urandom_range(0, 40)) - 12) % 1024 + 1024) % 1024;
      py = ((m_ay + int'($urandom_range(0, 40)) - 12) % 1024 + 1024) % 1024;
      wx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023));
      wy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023)) : int'($urandom_range(0, 1023));
      cycle($urandom_range(0, 9) != 0, px, py, 24'($urandom), $urandom_range(0, 4) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, wx, wy);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
